// File: rtl/pab_noc_pkg.sv
// Shared definitions for the permutation-network router channels.
// Holds flit field positions, the in-router tagged flit type and the
// default tag width / port index constants (E/N/W/S/L).
package pab_noc_pkg;

    localparam int unsigned DEF_FLIT_W = 64;
    localparam int unsigned DEF_TAG_W  = 3;

    // Router port indices, used as input-port tags
    localparam int unsigned PORT_E = 0;
    localparam int unsigned PORT_N = 1;
    localparam int unsigned PORT_W = 2;
    localparam int unsigned PORT_S = 3;
    localparam int unsigned PORT_L = 4;

    // In-router flit: input-port tag prepended to the link flit
    typedef struct packed {
        logic [DEF_TAG_W-1:0]  tag;
        logic [DEF_FLIT_W-1:0] flit;
    } rflit_t;

    // Position of the valid bit within a link flit of the given width
    function automatic int unsigned valid_idx(input int unsigned flit_w);
        return flit_w - 1;
    endfunction

endpackage

// File: rtl/swap_stage.sv
// One swap stage of the channel permutation network.
// Ports:
//   x_in      - tagged flit entering this stage
//   inner_in  - tagged flit offered by the partner channel
//   sel       - 1: exchange with partner, 0: pass straight through
//   x_out     - tagged flit leaving this stage
//   inner_out - tagged flit handed to the partner (0 when not swapping)
module swap_stage #(
    parameter int unsigned W = 67
) (
    input  logic [W-1:0] x_in,
    input  logic [W-1:0] inner_in,
    input  logic         sel,
    output logic [W-1:0] x_out,
    output logic [W-1:0] inner_out
);

    always_comb begin
        x_out     = x_in;
        inner_out = '0;
        if (sel) begin
            x_out     = inner_in;
            inner_out = x_in;
        end
    end

endmodule

// File: rtl/data_channel_param.sv
// Single-direction router data channel: input latch, ejection kill,
// local injection FIFO, swap-stage chain and registered output link.
// Also flags injection starvation for the router arbiter.
// Ports:
//   clk, reset    - clock, asynchronous active-low reset
//   in_flit       - upstream link flit (MSB = valid)
//   winner_tag/valid - ejection winner for this cycle
//   inj_valid/inj_flit/inj_ready - local injection handshake
//   swap, inner_in, inner_out    - swap-stage controls and partner links
//   out_flit      - registered downstream link flit
//   inj_level     - injection FIFO occupancy
//   starve        - injection blocked for STARVE_LIMIT cycles
module data_channel_param
    import pab_noc_pkg::*;
#(
    parameter int unsigned FLIT_W       = DEF_FLIT_W,
    parameter int unsigned TAG_W        = DEF_TAG_W,
    parameter int unsigned PORT_IDX     = PORT_E,
    parameter int unsigned N_SWAP       = 2,
    parameter int unsigned INJ_DEPTH    = 4,
    parameter int unsigned STARVE_LIMIT = 15
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [FLIT_W-1:0]                    in_flit,
    input  logic [TAG_W-1:0]                     winner_tag,
    input  logic                                 winner_valid,
    input  logic                                 inj_valid,
    input  logic [FLIT_W-1:0]                    inj_flit,
    output logic                                 inj_ready,
    input  logic [N_SWAP-1:0]                    swap,
    input  logic [N_SWAP*(FLIT_W+TAG_W)-1:0]     inner_in,
    output logic [N_SWAP*(FLIT_W+TAG_W)-1:0]     inner_out,
    output logic [FLIT_W-1:0]                    out_flit,
    output logic [$clog2(INJ_DEPTH+1)-1:0]       inj_level,
    output logic                                 starve
);

    localparam int unsigned IW    = FLIT_W + TAG_W;
    localparam int unsigned VLD   = valid_idx(FLIT_W);
    localparam int unsigned LVL_W = $clog2(INJ_DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(INJ_DEPTH);
    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [FLIT_W-1:0] in_latch_q,   in_latch_d;
    logic [IW-1:0]     pipe_latch_q, pipe_latch_d;
    logic [FLIT_W-1:0] out_flit_q,   out_flit_d;
    logic [FLIT_W-1:0] fifo_mem_q [INJ_DEPTH];
    logic [FLIT_W-1:0] fifo_mem_d [INJ_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  count_q,  count_d;
    logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
    logic              starve_q, starve_d;

    logic              fifo_empty, fifo_full;
    logic              kill, surv_v, grant, push;
    logic [FLIT_W-1:0] sel_flit, push_flit;

    logic [N_SWAP:0][IW-1:0] x_chain;
    logic                    unused_tag;

    // Kill, inject grant, FIFO bookkeeping and starvation counter
    always_comb begin
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == LVL_W'(INJ_DEPTH));
        kill       = winner_valid && (winner_tag == TAG_W'(PORT_IDX)) && in_latch_q[VLD];
        surv_v     = in_latch_q[VLD] & ~kill;
        grant      = ~surv_v & ~fifo_empty;
        push       = inj_valid & ~fifo_full;

        sel_flit      = in_latch_q;
        sel_flit[VLD] = surv_v;
        if (grant) begin
            sel_flit = fifo_mem_q[rd_ptr_q];
        end

        push_flit      = inj_flit;
        push_flit[VLD] = 1'b1;

        in_latch_d   = in_flit;
        pipe_latch_d = {TAG_W'(PORT_IDX), sel_flit};
        out_flit_d   = x_chain[N_SWAP][FLIT_W-1:0];

        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (push) begin
            fifo_mem_d[wr_ptr_q] = push_flit;
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
        end
        if (grant) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, grant})
            2'b10:   count_d = count_q + LVL_W'(1);
            2'b01:   count_d = count_q - LVL_W'(1);
            default: count_d = count_q;
        endcase

        // Counts cycles the FIFO head waited behind a valid link flit
        starve_cnt_d = starve_cnt_q;
        if (grant || fifo_empty) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != CNT_W'(STARVE_LIMIT)) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end
        starve_d = (starve_cnt_q == CNT_W'(STARVE_LIMIT));
    end

    // Swap chain: stage k works on x_chain[k]
    assign x_chain[0] = pipe_latch_q;

    for (genvar k = 0; k < N_SWAP; k++) begin : g_swap
        swap_stage #(.W(IW)) u_swap_stage (
            .x_in      (x_chain[k]),
            .inner_in  (inner_in[k*IW +: IW]),
            .sel       (swap[k]),
            .x_out     (x_chain[k+1]),
            .inner_out (inner_out[k*IW +: IW])
        );
    end

    // Tag is dropped on the output link
    assign unused_tag = ^x_chain[N_SWAP][IW-1:FLIT_W];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_latch_q   <= '0;
            pipe_latch_q <= '0;
            out_flit_q   <= '0;
            for (int i = 0; i < int'(INJ_DEPTH); i++) begin
                fifo_mem_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            starve_cnt_q <= '0;
            starve_q     <= 1'b0;
        end else begin
            in_latch_q   <= in_latch_d;
            pipe_latch_q <= pipe_latch_d;
            out_flit_q   <= out_flit_d;
            fifo_mem_q   <= fifo_mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            starve_cnt_q <= starve_cnt_d;
            starve_q     <= starve_d;
        end
    end

    assign out_flit  = out_flit_q;
    assign inj_level = count_q;
    assign inj_ready = ~fifo_full;
    assign starve    = starve_q;

endmodule

// File: tb/tb_data_channel_param.sv
// Directed bench for data_channel_param with default parameters.
module tb_data_channel_param;
    import pab_noc_pkg::*;

    localparam int unsigned FLIT_W = 64;
    localparam int unsigned TAG_W  = 3;
    localparam int unsigned N_SWAP = 2;
    localparam int unsigned IW     = FLIT_W + TAG_W;

    logic                   clk;
    logic                   reset;
    logic [FLIT_W-1:0]      in_flit;
    logic [TAG_W-1:0]       winner_tag;
    logic                   winner_valid;
    logic                   inj_valid;
    logic [FLIT_W-1:0]      inj_flit;
    logic                   inj_ready;
    logic [N_SWAP-1:0]      swap;
    logic [N_SWAP*IW-1:0]   inner_in;
    logic [N_SWAP*IW-1:0]   inner_out;
    logic [FLIT_W-1:0]      out_flit;
    logic [2:0]             inj_level;
    logic                   starve;

    int errors = 0;
    int checks = 0;

    data_channel_param #(
        .FLIT_W(FLIT_W), .TAG_W(TAG_W), .PORT_IDX(0), .N_SWAP(N_SWAP),
        .INJ_DEPTH(4), .STARVE_LIMIT(15)
    ) dut (
        .clk(clk), .reset(reset), .in_flit(in_flit),
        .winner_tag(winner_tag), .winner_valid(winner_valid),
        .inj_valid(inj_valid), .inj_flit(inj_flit), .inj_ready(inj_ready),
        .swap(swap), .inner_in(inner_in), .inner_out(inner_out),
        .out_flit(out_flit), .inj_level(inj_level), .starve(starve)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; in_flit = '0; winner_tag = '0; winner_valid = 1'b0;
        inj_valid = 1'b0; inj_flit = '0; swap = '0; inner_in = '0;
        tick(); tick();
        checks++; if (out_flit !== 64'h0) begin errors++; $display("FAIL reset_out: got %h exp %h", out_flit, 64'h0); end
        checks++; if (inj_level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d exp 0", inj_level); end
        checks++; if (inj_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b exp 1", inj_ready); end
        checks++; if (starve !== 1'b0) begin errors++; $display("FAIL reset_starve: got %b exp 0", starve); end
        checks++; if (inner_out !== '0) begin errors++; $display("FAIL reset_inner: got %h exp 0", inner_out); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_pass_through();
        in_flit = 64'h8000_0000_0000_00A5;
        tick();
        in_flit = '0;
        tick();
        checks++; if (out_flit !== 64'h0) begin errors++; $display("FAIL pass_early: got %h exp %h", out_flit, 64'h0); end
        tick();
        checks++; if (out_flit !== 64'h8000_0000_0000_00A5) begin errors++; $display("FAIL pass_out: got %h exp %h", out_flit, 64'h8000_0000_0000_00A5); end
        checks++; if (inj_level !== 3'd0) begin errors++; $display("FAIL pass_level: got %0d exp 0", inj_level); end
    endtask

    task automatic test_kill_inject();
        in_flit = 64'h8000_0000_0000_0077; inj_valid = 1'b1; inj_flit = 64'h11;
        tick();
        checks++; if (inj_level !== 3'd1) begin errors++; $display("FAIL kill_level_push: got %0d exp 1", inj_level); end
        in_flit = '0; inj_valid = 1'b0; winner_valid = 1'b1; winner_tag = 3'd0;
        tick();
        checks++; if (inj_level !== 3'd0) begin errors++; $display("FAIL kill_level_pop: got %0d exp 0", inj_level); end
        winner_valid = 1'b0;
        tick();
        checks++; if (out_flit !== 64'h8000_0000_0000_0011) begin errors++; $display("FAIL kill_out: got %h exp %h", out_flit, 64'h8000_0000_0000_0011); end
        // Winner for another port must not kill this channel's flit
        in_flit = 64'h8000_0000_0000_00BB;
        tick();
        in_flit = '0; winner_valid = 1'b1; winner_tag = 3'd2;
        tick();
        winner_valid = 1'b0;
        tick();
        checks++; if (out_flit !== 64'h8000_0000_0000_00BB) begin errors++; $display("FAIL nokill_out: got %h exp %h", out_flit, 64'h8000_0000_0000_00BB); end
    endtask

    task automatic test_fifo_full();
        logic [FLIT_W-1:0] exp_f;
        for (int i = 0; i < 4; i++) begin
            in_flit = 64'h8000_0000_0000_0100 + 64'(i);
            inj_valid = 1'b1; inj_flit = 64'hD0 + 64'(i);
            tick();
        end
        checks++; if (inj_level !== 3'd4) begin errors++; $display("FAIL full_level: got %0d exp 4", inj_level); end
        checks++; if (inj_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b exp 0", inj_ready); end
        in_flit = 64'h8000_0000_0000_0104; inj_flit = 64'hEE;
        tick();
        checks++; if (inj_level !== 3'd4) begin errors++; $display("FAIL full_reject: got %0d exp 4", inj_level); end
        in_flit = '0; inj_valid = 1'b0;
        tick(); tick(); tick();
        for (int i = 0; i < 4; i++) begin
            exp_f = 64'h8000_0000_0000_00D0 + 64'(i);
            checks++; if (out_flit !== exp_f) begin errors++; $display("FAIL drain_%0d: got %h exp %h", i, out_flit, exp_f); end
            if (i < 3) tick();
        end
        checks++; if (inj_level !== 3'd0) begin errors++; $display("FAIL drain_level: got %0d exp 0", inj_level); end
        checks++; if (inj_ready !== 1'b1) begin errors++; $display("FAIL drain_ready: got %b exp 1", inj_ready); end
        // Refill after pointer wrap
        inj_valid = 1'b1; inj_flit = 64'hF0;
        tick();
        inj_valid = 1'b0;
        tick(); tick();
        checks++; if (out_flit !== 64'h8000_0000_0000_00F0) begin errors++; $display("FAIL wrap_out: got %h exp %h", out_flit, 64'h8000_0000_0000_00F0); end
    endtask

    task automatic test_swap_chain();
        rflit_t r0, r1;
        // swap = 01
        in_flit = 64'h8000_0000_0000_0033; tick(); in_flit = '0; tick();
        r0 = '{tag: 3'd1, flit: 64'h8000_0000_0000_0022};
        swap = 2'b01; inner_in = {67'h0, r0};
        #1;
        checks++; if (inner_out[IW-1:0] !== {3'd0, 64'h8000_0000_0000_0033}) begin errors++; $display("FAIL swap01_inner0: got %h", inner_out[IW-1:0]); end
        checks++; if (inner_out[2*IW-1:IW] !== 67'h0) begin errors++; $display("FAIL swap01_inner1: got %h exp 0", inner_out[2*IW-1:IW]); end
        tick();
        checks++; if (out_flit !== 64'h8000_0000_0000_0022) begin errors++; $display("FAIL swap01_out: got %h exp %h", out_flit, 64'h8000_0000_0000_0022); end
        swap = '0; inner_in = '0;
        // swap = 10
        in_flit = 64'h8000_0000_0000_0055; tick(); in_flit = '0; tick();
        r1 = '{tag: 3'd2, flit: 64'h8000_0000_0000_0044};
        swap = 2'b10; inner_in = {r1, 67'h0};
        #1;
        checks++; if (inner_out[IW-1:0] !== 67'h0) begin errors++; $display("FAIL swap10_inner0: got %h exp 0", inner_out[IW-1:0]); end
        checks++; if (inner_out[2*IW-1:IW] !== {3'd0, 64'h8000_0000_0000_0055}) begin errors++; $display("FAIL swap10_inner1: got %h", inner_out[2*IW-1:IW]); end
        tick();
        checks++; if (out_flit !== 64'h8000_0000_0000_0044) begin errors++; $display("FAIL swap10_out: got %h exp %h", out_flit, 64'h8000_0000_0000_0044); end
        swap = '0; inner_in = '0;
        // swap = 11
        in_flit = 64'h8000_0000_0000_0088; tick(); in_flit = '0; tick();
        r0 = '{tag: 3'd1, flit: 64'h8000_0000_0000_0066};
        r1 = '{tag: 3'd2, flit: 64'h8000_0000_0000_0077};
        swap = 2'b11; inner_in = {r1, r0};
        #1;
        checks++; if (inner_out[IW-1:0] !== {3'd0, 64'h8000_0000_0000_0088}) begin errors++; $display("FAIL swap11_inner0: got %h", inner_out[IW-1:0]); end
        checks++; if (inner_out[2*IW-1:IW] !== {3'd1, 64'h8000_0000_0000_0066}) begin errors++; $display("FAIL swap11_inner1: got %h", inner_out[2*IW-1:IW]); end
        tick();
        checks++; if (out_flit !== 64'h8000_0000_0000_0077) begin errors++; $display("FAIL swap11_out: got %h exp %h", out_flit, 64'h8000_0000_0000_0077); end
        swap = '0; inner_in = '0;
        tick();
    endtask

    task automatic test_starvation();
        in_flit = 64'h8000_0000_0000_0005; inj_valid = 1'b1; inj_flit = 64'h99;
        tick();
        inj_valid = 1'b0;
        repeat (15) tick();
        checks++; if (starve !== 1'b0) begin errors++; $display("FAIL starve_early: got %b exp 0", starve); end
        tick();
        checks++; if (starve !== 1'b1) begin errors++; $display("FAIL starve_set: got %b exp 1", starve); end
        in_flit = '0;
        tick();
        checks++; if (starve !== 1'b1) begin errors++; $display("FAIL starve_hold: got %b exp 1", starve); end
        tick();
        checks++; if (starve !== 1'b1) begin errors++; $display("FAIL starve_grant_edge: got %b exp 1", starve); end
        tick();
        checks++; if (starve !== 1'b0) begin errors++; $display("FAIL starve_clear: got %b exp 0", starve); end
        checks++; if (out_flit !== 64'h8000_0000_0000_0099) begin errors++; $display("FAIL starve_out: got %h exp %h", out_flit, 64'h8000_0000_0000_0099); end
        checks++; if (inj_level !== 3'd0) begin errors++; $display("FAIL starve_level: got %0d exp 0", inj_level); end
    endtask

    task automatic test_reset_mid_op();
        in_flit = 64'h8000_0000_0000_00C0;
        for (int i = 0; i < 3; i++) begin
            inj_valid = 1'b1; inj_flit = 64'hA0 + 64'(i);
            tick();
        end
        inj_valid = 1'b0;
        checks++; if (inj_level !== 3'd3) begin errors++; $display("FAIL mid_level: got %0d exp 3", inj_level); end
        checks++; if (out_flit !== 64'h8000_0000_0000_00C0) begin errors++; $display("FAIL mid_out: got %h exp %h", out_flit, 64'h8000_0000_0000_00C0); end
        #2;
        reset = 1'b0;
        #1;
        checks++; if (inj_level !== 3'd0) begin errors++; $display("FAIL rst_level: got %0d exp 0", inj_level); end
        checks++; if (out_flit !== 64'h0) begin errors++; $display("FAIL rst_out: got %h exp 0", out_flit); end
        checks++; if (inj_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b exp 1", inj_ready); end
        checks++; if (starve !== 1'b0) begin errors++; $display("FAIL rst_starve: got %b exp 0", starve); end
        tick();
        reset = 1'b1; in_flit = '0;
        tick(); tick(); tick();
        checks++; if (inj_level !== 3'd0) begin errors++; $display("FAIL post_rst_level: got %0d exp 0", inj_level); end
        checks++; if (out_flit !== 64'h0) begin errors++; $display("FAIL post_rst_out: got %h exp 0", out_flit); end
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_kill_inject();
        test_fifo_full();
        test_swap_chain();
        test_starvation();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
